// File: rtl/display_capture.sv
`default_nettype none
// ============================================================================
// Module   : display_capture
// Brief    : Receive end of a 4-digit multiplexed 7-segment bus. Settles,
//            decodes and reassembles LB/HB/dp_mask. Optional stale watchdog
//            enabled by defining DISPLAY_CAPTURE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module display_capture #(
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] AN,
    input  logic [6:0] seg,
    input  logic       seg_P,
    output logic [7:0] LB,
    output logic [7:0] HB,
    output logic [3:0] dp_mask,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       stale
);

    localparam int                 c_CNT_W    = $clog2(SETTLE + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(SETTLE);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SETTLE - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_HELD   = 2'd2;

    // Returns {bad, nibble}; unknown patterns decode to nibble 0 with bad set.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] v;
        case (s)
            7'b1000000: v = 5'h00;
            7'b1111001: v = 5'h01;
            7'b0100100: v = 5'h02;
            7'b0110000: v = 5'h03;
            7'b0011001: v = 5'h04;
            7'b0010010: v = 5'h05;
            7'b0000010: v = 5'h06;
            7'b1111000: v = 5'h07;
            7'b0000000: v = 5'h08;
            7'b0010000: v = 5'h09;
            7'b0001000: v = 5'h0A;
            7'b0000011: v = 5'h0B;
            7'b1000110: v = 5'h0C;
            7'b0100001: v = 5'h0D;
            7'b0000110: v = 5'h0E;
            7'b0001110: v = 5'h0F;
            default:    v = 5'h10;
        endcase
        return v;
    endfunction

    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_segp;
    logic [11:0]        r_prev;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [3:0][3:0]    r_nib;
    logic [3:0]         r_sdp;
    logic [3:0]         r_bad;
    logic [3:0]         r_captured;
    logic [7:0]         r_lb;
    logic [7:0]         r_hb;
    logic [3:0]         r_dp_mask;
    logic               r_frame_valid;
    logic               r_frame_err;

    logic [11:0]        w_tuple;
    logic               w_changed;
    logic               w_an_valid;
    logic [1:0]         w_idx;
    logic               w_capture;
    logic [3:0]         w_cap_vec;
    logic [4:0]         w_dec;
    logic               w_complete;
    logic               w_timeout;
    logic [3:0]         w_bad_nxt;
    logic [3:0]         w_captured_nxt;

    // Sample stage plus one-deep history for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an   <= 4'hF;
            r_seg  <= 7'h7F;
            r_segp <= 1'b1;
            r_prev <= 12'hFFF;
        end else begin
            r_an   <= AN;
            r_seg  <= seg;
            r_segp <= seg_P;
            r_prev <= w_tuple;
        end
    end

    assign w_tuple   = {r_an, r_seg, r_segp};
    assign w_changed = (w_tuple != r_prev);
    assign w_dec     = decode_seg(r_seg);

    always_comb begin
        w_an_valid = 1'b1;
        w_idx      = 2'd0;
        case (r_an)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_an_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (w_an_valid) begin
                    w_state_nxt = c_ST_SETTLE;
                    w_cnt_nxt   = c_CNT_ONE;
                end
            end
            c_ST_SETTLE: begin
                if (w_changed) begin
                    w_state_nxt = w_an_valid ? c_ST_SETTLE : c_ST_IDLE;
                    w_cnt_nxt   = w_an_valid ? c_CNT_ONE : '0;
                end else begin
                    w_cnt_nxt = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = c_ST_HELD;
                    end
                end
            end
            c_ST_HELD: begin
                if (w_changed) begin
                    w_state_nxt = w_an_valid ? c_ST_SETTLE : c_ST_IDLE;
                    w_cnt_nxt   = w_an_valid ? c_CNT_ONE : '0;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Capture fires on the sample that brings the counter up to SETTLE.
    always_comb begin
        w_capture = (r_state == c_ST_SETTLE) && !w_changed && (r_cnt == c_CNT_LAST);
        w_cap_vec = w_capture ? (4'b0001 << w_idx) : 4'b0000;
    end

    assign w_complete = (r_captured == 4'b1111);

    // A capture landing on the completion cycle belongs to the next frame.
    always_comb begin
        w_bad_nxt      = w_complete ? 4'b0000 : r_bad;
        w_captured_nxt = (w_complete || w_timeout) ? 4'b0000 : r_captured;
        if (w_capture) begin
            w_bad_nxt[w_idx] = w_dec[4];
        end
        w_captured_nxt = w_captured_nxt | w_cap_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nib         <= '0;
            r_sdp         <= 4'b0000;
            r_bad         <= 4'b0000;
            r_captured    <= 4'b0000;
            r_lb          <= 8'h00;
            r_hb          <= 8'h00;
            r_dp_mask     <= 4'b0000;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_nib[w_idx] <= w_dec[3:0];
                r_sdp[w_idx] <= ~r_segp;
            end
            r_bad         <= w_bad_nxt;
            r_captured    <= w_captured_nxt;
            r_frame_valid <= w_complete;
            if (w_complete) begin
                r_lb        <= {r_nib[1], r_nib[0]};
                r_hb        <= {r_nib[3], r_nib[2]};
                r_dp_mask   <= r_sdp;
                r_frame_err <= |r_bad;
            end
        end
    end

    assign LB          = r_lb;
    assign HB          = r_hb;
    assign dp_mask     = r_dp_mask;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;

`ifdef DISPLAY_CAPTURE_TIMEOUT_EN
    localparam int                c_WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WD_W-1:0] c_WD_ONE  = c_WD_W'(1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    logic [c_WD_W-1:0] r_wd;
    logic              r_stale;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd    <= '0;
            r_stale <= 1'b0;
        end else if (w_complete) begin
            r_wd    <= '0;
            r_stale <= 1'b0;
        end else if (r_wd == c_WD_LAST) begin
            r_wd    <= '0;
            r_stale <= 1'b1;
        end else begin
            r_wd <= r_wd + c_WD_ONE;
        end
    end

    assign w_timeout = !w_complete && (r_wd == c_WD_LAST);
    assign stale     = r_stale;
`else
    // No watchdog in this build: stale is constantly 0.
    assign w_timeout = 1'b0;
    assign stale     = (TIMEOUT < 0);
`endif

endmodule
`default_nettype wire
